// File: rtl/disk_fsm_pkg.sv
// disk_fsm_pkg: shared constants, tables and helpers for disk_fsm_32bit.
// Build option: DISK_FSM_BASE5_EN makes select code 11 mean base 5.
package disk_fsm_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VDC    = 3'd1;
  localparam logic [2:0] ST_SQRT   = 3'd2;
  localparam logic [2:0] ST_CORDIC = 3'd3;
  localparam logic [2:0] ST_SCALE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [4:0] SQRT_LAST   = 5'd31;
  localparam logic [4:0] CORDIC_LAST = 5'd23;

  localparam logic signed [31:0] CORDIC_K = 32'sh26DD3B6A;

  // floor(2^32 / b^(i+1)); zero once b^(i+1) exceeds 2^32
  function automatic logic [31:0][31:0] gen_tab(input logic [63:0] b);
    logic [31:0][31:0] t;
    logic [63:0] p;
    t = '0;
    p = 64'd1;
    for (int i = 0; i < 32; i++) begin
      p = p * b;
      if (p <= 64'h1_0000_0000) begin
        t[i] = 32'(64'h1_0000_0000 / p);
      end else begin
        p = 64'h2_0000_0000;
      end
    end
    return t;
  endfunction

  localparam logic [31:0][31:0] INVPOW2 = gen_tab(64'd2);
  localparam logic [31:0][31:0] INVPOW3 = gen_tab(64'd3);
  localparam logic [31:0][31:0] INVPOW7 = gen_tab(64'd7);
`ifdef DISK_FSM_BASE5_EN
  localparam logic [31:0][31:0] INVPOW5 = gen_tab(64'd5);
`endif

  function automatic logic [2:0] base_of(input logic [1:0] sel);
    logic [2:0] b;
    case (sel)
      2'b01:   b = 3'd3;
      2'b10:   b = 3'd7;
`ifdef DISK_FSM_BASE5_EN
      2'b11:   b = 3'd5;
`endif
      default: b = 3'd2;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] div_base(
    input logic [1:0]  sel,
    input logic [31:0] k
  );
    logic [31:0] q;
    case (sel)
      2'b01:   q = k / 32'd3;
      2'b10:   q = k / 32'd7;
`ifdef DISK_FSM_BASE5_EN
      2'b11:   q = k / 32'd5;
`endif
      default: q = k >> 1;
    endcase
    return q;
  endfunction

  // digit weight; zero means the table for that base is exhausted
  function automatic logic [31:0] invpow(
    input logic [1:0] sel,
    input logic [5:0] idx
  );
    logic [31:0] w;
    w = '0;
    if (!idx[5]) begin
      case (sel)
        2'b01:   w = INVPOW3[idx[4:0]];
        2'b10:   w = INVPOW7[idx[4:0]];
`ifdef DISK_FSM_BASE5_EN
        2'b11:   w = INVPOW5[idx[4:0]];
`endif
        default: w = INVPOW2[idx[4:0]];
      endcase
    end
    return w;
  endfunction

  // atan(2^-i) in turns, Q0.32
  function automatic logic signed [31:0] atan_turns(input logic [4:0] i);
    logic signed [31:0] a;
    case (i)
      5'd0:    a = 32'sh20000000;
      5'd1:    a = 32'sh12E4051E;
      5'd2:    a = 32'sh09FB385B;
      5'd3:    a = 32'sh051111D4;
      5'd4:    a = 32'sh028B0D43;
      5'd5:    a = 32'sh0145D7E1;
      5'd6:    a = 32'sh00A2F61E;
      5'd7:    a = 32'sh00517C55;
      5'd8:    a = 32'sh0028BE53;
      5'd9:    a = 32'sh00145F2F;
      5'd10:   a = 32'sh000A2F98;
      5'd11:   a = 32'sh000517CC;
      5'd12:   a = 32'sh00028BE6;
      5'd13:   a = 32'sh000145F3;
      5'd14:   a = 32'sh0000A2FA;
      5'd15:   a = 32'sh0000517D;
      5'd16:   a = 32'sh000028BE;
      5'd17:   a = 32'sh0000145F;
      5'd18:   a = 32'sh00000A30;
      5'd19:   a = 32'sh00000518;
      5'd20:   a = 32'sh0000028C;
      5'd21:   a = 32'sh00000146;
      5'd22:   a = 32'sh000000A3;
      5'd23:   a = 32'sh00000051;
      default: a = 32'sh00000000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_sincos_seq.sv
// cordic_sincos_seq: 24-step rotation CORDIC, phase in turns (Q0.32),
// cos/sin out in Q2.30; quadrant handled by pre-rotating the start vector.
module cordic_sincos_seq
  import disk_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        phase,
  output logic               done,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out
);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         it_q, it_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic signed [31:0] xs, ys;

  // load on start, then one micro-rotation per cycle toward z = 0
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    it_d   = it_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    xs     = x_q >>> it_q;
    ys     = y_q >>> it_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        it_d   = 5'd0;
        z_d    = $signed({2'b00, phase[29:0]});
        case (phase[31:30])
          2'b00: begin x_d = CORDIC_K;  y_d = '0;        end
          2'b01: begin x_d = '0;        y_d = CORDIC_K;  end
          2'b10: begin x_d = -CORDIC_K; y_d = '0;        end
          default: begin x_d = '0;      y_d = -CORDIC_K; end
        endcase
      end
    end else begin
      if (!z_q[31]) begin
        x_d = x_q - ys;
        y_d = y_q + xs;
        z_d = z_q - atan_turns(it_q);
      end else begin
        x_d = x_q + ys;
        y_d = y_q - xs;
        z_d = z_q + atan_turns(it_q);
      end
      it_d = it_q + 5'd1;
      if (it_q == CORDIC_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // state registers, cleared by the active-high async reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      it_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      it_q   <= it_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
    end
  end

  assign done    = done_q;
  assign cos_out = x_q;
  assign sin_out = y_q;

endmodule

// File: rtl/disk_fsm_32bit.sv
// disk_fsm_32bit: one disk-sequence point per request (vdc, sqrt, CORDIC).
// Build option: DISK_FSM_BASE5_EN enables base 5 on select code 11.
module disk_fsm_32bit
  import disk_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] k_in,
  input  logic [1:0]  base_sel0,
  input  logic [1:0]  base_sel1,
  output logic [31:0] result_x,
  output logic [31:0] result_y,
  output logic        done,
  output logic        ready
);

  logic [2:0]  state_q, state_d;
  logic [31:0] k0_q, k0_d, k1_q, k1_d;
  logic [1:0]  sel0_q, sel0_d, sel1_q, sel1_d;
  logic [31:0] vdc0_q, vdc0_d, vdc1_q, vdc1_d;
  logic [5:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [35:0] rem_q, rem_d;
  logic [31:0] root_q, root_d;
  logic [63:0] rad_q, rad_d;
  logic [31:0] rx_q, rx_d, ry_q, ry_d;

  logic [31:0] q0, q1, d0, d1, w0, w1;
  logic        act0, act1, more0, more1;
  logic [5:0]  idx_n;
  logic [35:0] rem_s, trial;
  logic [63:0] px, py;
  logic        cor_start, cor_done;
  logic signed [31:0] cos_w, sin_w;

  cordic_sincos_seq u_cordic (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (cor_start),
    .phase   (vdc0_q),
    .done    (cor_done),
    .cos_out (cos_w),
    .sin_out (sin_w)
  );

  assign cor_start = (state_q == ST_SQRT) && (cnt_q == SQRT_LAST);

  // sequencing plus the inline vdc digit loop and restoring sqrt
  always_comb begin
    state_d = state_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    sel0_d  = sel0_q;
    sel1_d  = sel1_q;
    vdc0_d  = vdc0_q;
    vdc1_d  = vdc1_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    root_d  = root_q;
    rad_d   = rad_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    more0   = 1'b0;
    more1   = 1'b0;
    q0      = div_base(sel0_q, k0_q);
    q1      = div_base(sel1_q, k1_q);
    d0      = k0_q - q0 * {29'd0, base_of(sel0_q)};
    d1      = k1_q - q1 * {29'd0, base_of(sel1_q)};
    w0      = invpow(sel0_q, idx_q);
    w1      = invpow(sel1_q, idx_q);
    act0    = (k0_q != '0) && (w0 != '0);
    act1    = (k1_q != '0) && (w1 != '0);
    idx_n   = idx_q + 6'd1;
    rem_s   = (rem_q << 2) | {34'd0, rad_q[63:62]};
    trial   = {2'b00, root_q, 2'b01};
    px      = {{32{cos_w[31]}}, cos_w} * {32'd0, root_q};
    py      = {{32{sin_w[31]}}, sin_w} * {32'd0, root_q};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k0_d    = k_in;
          k1_d    = k_in;
          sel0_d  = base_sel0;
          sel1_d  = base_sel1;
          vdc0_d  = '0;
          vdc1_d  = '0;
          idx_d   = '0;
          state_d = ST_VDC;
        end
      end
      ST_VDC: begin
        if (act0) begin
          k0_d   = q0;
          vdc0_d = vdc0_q + w0 * d0;
        end
        if (act1) begin
          k1_d   = q1;
          vdc1_d = vdc1_q + w1 * d1;
        end
        idx_d = idx_n;
        more0 = (k0_d != '0) && (invpow(sel0_q, idx_n) != '0);
        more1 = (k1_d != '0) && (invpow(sel1_q, idx_n) != '0);
        if (!more0 && !more1) begin
          state_d = ST_SQRT;
          cnt_d   = '0;
          rem_d   = '0;
          root_d  = '0;
          rad_d   = {vdc1_d, 32'd0};
        end
      end
      ST_SQRT: begin
        if (rem_s >= trial) begin
          rem_d  = rem_s - trial;
          root_d = {root_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_s;
          root_d = {root_q[30:0], 1'b0};
        end
        rad_d = rad_q << 2;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == SQRT_LAST) begin
          state_d = ST_CORDIC;
        end
      end
      ST_CORDIC: begin
        if (cor_done) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        rx_d    = 32'(px >> 32);
        ry_d    = 32'(py >> 32);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // registers; reset aborts any computation and clears results
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      k0_q    <= '0;
      k1_q    <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
      vdc0_q  <= '0;
      vdc1_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      rad_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      state_q <= state_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      vdc0_q  <= vdc0_d;
      vdc1_q  <= vdc1_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      rad_q   <= rad_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
    end
  end

  assign result_x = rx_q;
  assign result_y = ry_q;
  assign done     = (state_q == ST_DONE);
  assign ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_disk_fsm_32bit.sv
// tb_disk_fsm_32bit: directed checks of disk_fsm_32bit against
// hand-computed Q2.30 points, handshake timing and reset behaviour.
module tb_disk_fsm_32bit;

  localparam longint TOL = 64'sd4096;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] k_in;
  logic [1:0]  base_sel0;
  logic [1:0]  base_sel1;
  logic [31:0] result_x;
  logic [31:0] result_y;
  logic        done;
  logic        ready;

  int tests;
  int fails;
  int lat;

  disk_fsm_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_in      (k_in),
    .base_sel0 (base_sel0),
    .base_sel1 (base_sel1),
    .result_x  (result_x),
    .result_y  (result_y),
    .done      (done),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    longint d;
    d = longint'($signed(obs)) - longint'($signed(exp));
    tests++;
    assert (d <= TOL && d >= -TOL) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag,
             $signed(obs), $signed(exp), TOL);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue one request; optionally pulse start again while busy
  task automatic run_req(input logic [31:0] k, input logic [1:0] s0,
                         input logic [1:0] s1, input int glitch,
                         output int latency);
    bit seen;
    start     = 1'b1;
    k_in      = k;
    base_sel0 = s0;
    base_sel1 = s1;
    step();
    start = 1'b0;
    chk_eq("ready_drop", {31'd0, ready}, 32'd0);
    seen    = 1'b0;
    latency = 0;
    for (int c = 1; c <= 120 && !seen; c++) begin
      if (c == glitch) begin
        start     = 1'b1;
        k_in      = 32'd2;
        base_sel0 = 2'b01;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        seen    = 1'b1;
        latency = c;
      end
    end
    start = 1'b0;
    chk_eq("done_seen", {31'd0, seen}, 32'd1);
    chk_eq("latency_ok", {31'd0, (latency <= 90 && latency >= 2)},
           32'd1);
  endtask

  task automatic post_done();
    step();
    chk_eq("done_pulse", {31'd0, done}, 32'd0);
    chk_eq("ready_back", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    k_in      = '0;
    base_sel0 = 2'b00;
    base_sel1 = 2'b00;
    repeat (3) step();
    chk_eq("rst_ready", {31'd0, ready}, 32'd1);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    chk_eq("rst_x", result_x, 32'd0);
    chk_eq("rst_y", result_y, 32'd0);
    rst_n = 1'b0;
    repeat (2) step();
    chk_eq("idle_ready", {31'd0, ready}, 32'd1);
    chk_eq("idle_done", {31'd0, done}, 32'd0);
    chk_eq("idle_x", result_x, 32'd0);
    chk_eq("idle_y", result_y, 32'd0);

    run_req(32'd1, 2'b00, 2'b01, 0, lat);
    chk_near("k1_b23_x", result_x, -32'sd619925131);
    chk_near("k1_b23_y", result_y, 32'sd0);
    post_done();

    run_req(32'd2, 2'b00, 2'b01, 0, lat);
    chk_near("k2_b23_x", result_x, 32'sd0);
    chk_near("k2_b23_y", result_y, 32'sd876706528);
    post_done();

    run_req(32'd1, 2'b01, 2'b10, 0, lat);
    chk_near("k1_b37_x", result_x, -32'sd202918131);
    chk_near("k1_b37_y", result_y, 32'sd351464514);
    post_done();

    run_req(32'd5, 2'b00, 2'b00, 0, lat);
    chk_near("k5_b22_x", result_x, -32'sd600239927);
    chk_near("k5_b22_y", result_y, -32'sd600239927);
    post_done();

    run_req(32'd0, 2'b01, 2'b10, 0, lat);
    chk_eq("k0_x", result_x, 32'd0);
    chk_eq("k0_y", result_y, 32'd0);
    post_done();

    run_req(32'd1, 2'b00, 2'b01, 5, lat);
    chk_near("busy_x", result_x, -32'sd619925131);
    chk_near("busy_y", result_y, 32'sd0);
    post_done();
    chk_near("hold_x", result_x, -32'sd619925131);

    start     = 1'b1;
    k_in      = 32'd1;
    base_sel0 = 2'b01;
    base_sel1 = 2'b10;
    step();
    start = 1'b0;
    repeat (39) step();
    rst_n = 1'b1;
    #1;
    chk_eq("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk_eq("mid_rst_done", {31'd0, done}, 32'd0);
    chk_eq("mid_rst_x", result_x, 32'd0);
    chk_eq("mid_rst_y", result_y, 32'd0);
    step();
    rst_n = 1'b0;
    step();

    run_req(32'd2, 2'b00, 2'b01, 0, lat);
    chk_near("after_rst_x", result_x, 32'sd0);
    chk_near("after_rst_y", result_y, 32'sd876706528);
    post_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
